estagio_ula_ex: RTL
===================

// Module: estagio_ula_ex
// PURPOSE
//  Execute-stage front end of the ALU. Decodes aluOp/funct into the 4-bit operation code.
//  Computes all six candidate results: AND, OR, ADD, SUB, SLT, NOR.
//  Registers results, code and flags in one valid/ready pipeline stage.
//  Directly drives the six 32-bit inputs and the selector of the downstream 6-way result mux.
// PARAMETERS
//  LARGURA  32  operand/result width (mux is 32-bit; only 32 is supported)
// PORTS
//  clock           in   1   single clock, rising edge
//  reset           in   1   asynchronous, active-high
//  flush           in   1   sync kill: clears valido_saida next edge (priority over load)
//  valido_entrada  in   1   upstream holds a valid op this cycle
//  pronto_entrada  out  1   stage can accept: ~valido_saida | pronto_saida (combinational)
//  operandoA       in   32  rs value
//  operandoB       in   32  rt value / sign-extended immediate
//  aluOp           in   2   00=add, 01=sub, 10=R-type (use funct), 11=illegal
//  funct           in   6   R-type function field
//  valido_saida    out  1   registered outputs hold a valid op
//  pronto_saida    in   1   downstream consumes when valido_saida & pronto_saida
//  entrada1..6     out  32  regd AND, OR, ADD, SUB, SLT, NOR results (in mux input order)
//  seletor         out  4   regd op code: 0000 AND,0001 OR,0010 ADD,0110 SUB,0111 SLT,1100 NOR
//  zero            out  1   regd: selected result == 0
//  overflow        out  1   regd signed overflow; only for ADD/SUB codes, else 0
//  erro_op         out  1   regd: illegal aluOp or unsupported funct
// BEHAVIOUR
//  - Reset: every output register = 0, including valido_saida.
//    pronto_entrada therefore = 1 during and after reset.
//  - Load condition: carga = valido_entrada & pronto_entrada & ~flush.
//    On carga, all data and flag registers update at the next edge; latency is exactly 1 cycle.
//  - Hold: if valido_saida & ~pronto_saida & ~flush, all registers hold unchanged (stall).
//  - valido_saida next-state priority: flush -> 0; else carga -> 1; else pronto_saida -> 0;
//    else hold.
//  - Simultaneous consume + load: the new op replaces the old in the same edge (full throughput).
//  - Flush while valido_entrada=1: the incoming op is dropped, not loaded.
//  - Data registers may keep stale values when valido_saida=0; consumers must qualify with valid.
//  - Decode for aluOp=10 (funct -> seletor):
//    100000 -> 0010, 100010 -> 0110, 100100 -> 0000,
//    100101 -> 0001, 101010 -> 0111, 100111 -> 1100.
//  - Illegal op (aluOp=11 or unlisted funct): seletor=0010 (ADD), erro_op=1, still loaded as valid.
//  - Arithmetic: ADD and SUB wrap mod 2^32.
//    Overflow: ADD = sign(A)==sign(B) & sign(sum)!=sign(A);
//    SUB = sign(A)!=sign(B) & sign(diff)!=sign(A).
//  - SLT is signed: bit0 = diff[31] ^ ovf_sub, bits[31:1] = 0.
//  - zero: computed on the result matching seletor, before registering.
//  - Reset asserted mid-stall: outputs clear immediately (async); the pending op is lost.
// STRUCTURE
//  - Shared package ula_defs:
//    seletor codes: SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT, SEL_NOR;
//    aluOp codes: ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_ILEGAL;
//    funct codes: F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR.
//  - Sub-module ula_controle: combinational (aluOp, funct) -> (seletor, erro_op).
//    Shared with the hazard unit.
//  - Datapath and pipeline register stay in this module.
// TESTING
//  1. Reset mid-stall, with valido_saida=1 and pronto_saida=0:
//     all outputs 0 immediately; pronto_entrada=1 after reset.
//  2. A=7, B=5, aluOp=10, funct=101010, pronto_saida=1:
//     after 1 edge entrada5=0, seletor=0111, zero=1.
//     Repeat with A=-1, B=5: entrada5=1, zero=0.
//  3. A=0x7FFFFFFF, B=1, aluOp=00:
//     entrada3=0x80000000, seletor=0010, overflow=1, zero=0.
//     Same operands, aluOp=01: entrada4=0x7FFFFFFE, overflow=0.
//  4. Stall: load op X, then hold pronto_saida=0 for 3 cycles while presenting op Y.
//     Outputs stay X and pronto_entrada=0; on pronto_saida=1, Y appears the next edge.
//  5. Flush: flush=1 with valido_entrada=1 -> valido_saida=0 next edge, and the op is not loaded.
//     flush=1 while stalled -> valido_saida=0.
//  6. Illegal ops, one per case:
//     aluOp=11 -> erro_op=1, seletor=0010.
//     funct=000000 -> erro_op=1.
//     funct=100111, A=0, B=0 -> entrada6=0xFFFFFFFF, seletor=1100.

Source files
------------

// File: rtl/ula_defs_pkg.sv
// Shared ALU encodings: result-mux selector codes, aluOp classes and R-type funct values.
// Used by the execute stage and by the hazard unit through ula_controle.
package ula_defs;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_ILEGAL = 2'b11;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    typedef struct packed {
        logic [3:0] seletor;
        logic       erro_op;
    } ula_ctrl_t;

endpackage

// File: rtl/ula_controle.sv
// Combinational ALU control: (aluOp, funct) -> mux selector plus illegal-op flag.
// Illegal encodings fall back to ADD so the datapath always produces a defined result.
module ula_controle
    import ula_defs::*;
(
    input  logic [1:0] aluOp_i,
    input  logic [5:0] funct_i,
    output logic [3:0] seletor_o,
    output logic       erro_op_o
);

    ula_ctrl_t ctrl;

    always_comb begin
        ctrl = '{seletor: SEL_ADD, erro_op: 1'b0};
        case (aluOp_i)
            ALUOP_ADD: ctrl.seletor = SEL_ADD;
            ALUOP_SUB: ctrl.seletor = SEL_SUB;
            ALUOP_R: begin
                case (funct_i)
                    F_ADD:   ctrl.seletor = SEL_ADD;
                    F_SUB:   ctrl.seletor = SEL_SUB;
                    F_AND:   ctrl.seletor = SEL_AND;
                    F_OR:    ctrl.seletor = SEL_OR;
                    F_SLT:   ctrl.seletor = SEL_SLT;
                    F_NOR:   ctrl.seletor = SEL_NOR;
                    default: ctrl.erro_op = 1'b1;
                endcase
            end
            default: ctrl.erro_op = 1'b1;
        endcase
    end

    assign seletor_o = ctrl.seletor;
    assign erro_op_o = ctrl.erro_op;

endmodule

// File: rtl/estagio_ula_ex.sv
// Execute-stage ALU front end: computes all six candidate results and registers them,
// the selector and the flags in a single valid/ready stage feeding the 6-way result mux.
module estagio_ula_ex
    import ula_defs::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               valido_entrada,
    output logic               pronto_entrada,
    input  logic [LARGURA-1:0] operandoA,
    input  logic [LARGURA-1:0] operandoB,
    input  logic [1:0]         aluOp,
    input  logic [5:0]         funct,
    output logic               valido_saida,
    input  logic               pronto_saida,
    output logic [LARGURA-1:0] entrada1,
    output logic [LARGURA-1:0] entrada2,
    output logic [LARGURA-1:0] entrada3,
    output logic [LARGURA-1:0] entrada4,
    output logic [LARGURA-1:0] entrada5,
    output logic [LARGURA-1:0] entrada6,
    output logic [3:0]         seletor,
    output logic               zero,
    output logic               overflow,
    output logic               erro_op
);

    localparam int MSB = LARGURA - 1;

    function automatic logic ovf_soma(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    logic [3:0]         sel_w;
    logic               erro_w;
    logic [LARGURA-1:0] and_w, or_w, add_w, sub_w, slt_w, nor_w, res_sel_w;
    logic               ovf_add_w, ovf_sub_w, ovf_w;
    logic               carga;

    logic [LARGURA-1:0] and_q, or_q, add_q, sub_q, slt_q, nor_q;
    logic [3:0]         sel_q;
    logic               zero_q, ovf_q, erro_q, valido_q;
    logic               valido_d;

    ula_controle u_controle (
        .aluOp_i   (aluOp),
        .funct_i   (funct),
        .seletor_o (sel_w),
        .erro_op_o (erro_w)
    );

    assign and_w     = operandoA & operandoB;
    assign or_w      = operandoA | operandoB;
    assign nor_w     = ~(operandoA | operandoB);
    assign add_w     = operandoA + operandoB;
    assign sub_w     = operandoA - operandoB;
    assign ovf_add_w = ovf_soma(operandoA[MSB], operandoB[MSB], add_w[MSB]);
    assign ovf_sub_w = ovf_sub(operandoA[MSB], operandoB[MSB], sub_w[MSB]);
    // Signed compare: the sign of the difference is wrong exactly when it overflowed.
    assign slt_w     = {{(LARGURA-1){1'b0}}, sub_w[MSB] ^ ovf_sub_w};

    always_comb begin
        res_sel_w = add_w;
        ovf_w     = 1'b0;
        case (sel_w)
            SEL_AND: res_sel_w = and_w;
            SEL_OR:  res_sel_w = or_w;
            SEL_ADD: begin res_sel_w = add_w; ovf_w = ovf_add_w; end
            SEL_SUB: begin res_sel_w = sub_w; ovf_w = ovf_sub_w; end
            SEL_SLT: res_sel_w = slt_w;
            SEL_NOR: res_sel_w = nor_w;
            default: res_sel_w = add_w;
        endcase
    end

    assign pronto_entrada = ~valido_q | pronto_saida;
    assign carga          = valido_entrada & pronto_entrada & ~flush;

    always_comb begin
        valido_d = valido_q;
        if (flush)             valido_d = 1'b0;
        else if (carga)        valido_d = 1'b1;
        else if (pronto_saida) valido_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valido_q <= 1'b0;
            and_q    <= '0;
            or_q     <= '0;
            add_q    <= '0;
            sub_q    <= '0;
            slt_q    <= '0;
            nor_q    <= '0;
            sel_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            valido_q <= valido_d;
            if (carga) begin
                and_q  <= and_w;
                or_q   <= or_w;
                add_q  <= add_w;
                sub_q  <= sub_w;
                slt_q  <= slt_w;
                nor_q  <= nor_w;
                sel_q  <= sel_w;
                zero_q <= (res_sel_w == '0);
                ovf_q  <= ovf_w;
                erro_q <= erro_w;
            end
        end
    end

    assign valido_saida = valido_q;
    assign entrada1     = and_q;
    assign entrada2     = or_q;
    assign entrada3     = add_q;
    assign entrada4     = sub_q;
    assign entrada5     = slt_q;
    assign entrada6     = nor_q;
    assign seletor      = sel_q;
    assign zero         = zero_q;
    assign overflow     = ovf_q;
    assign erro_op      = erro_q;

endmodule
